// File: rtl/scope_trace_scheduler_if.sv
// Sample stream, video-side and status signals between the oscilloscope trace
// scheduler and its environment. clk/rst_n stay plain ports on the modules.
//   enable        level, 1 = run acquisition
//   sample_in     12-bit unsigned ADC sample, qualified by sample_valid
//   sample_ready  scheduler accepts a sample (transfer = valid & ready)
//   frame_start   one-cycle vsync pulse
//   pixel_x       current display column
//   display_value registered sample for the column, 1-cycle latency
//   display_valid at least one complete trace has been published
//   capture_done  one-cycle pulse on bank swap
// modport slave is the scheduler, modport master is the driving side.
interface scope_trace_scheduler_if;
    logic        enable;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        frame_start;
    logic [9:0]  pixel_x;
    logic [11:0] display_value;
    logic        display_valid;
    logic        capture_done;

    modport slave (
        input  enable, sample_in, sample_valid, frame_start, pixel_x,
        output sample_ready, display_value, display_valid, capture_done
    );

    modport master (
        output enable, sample_in, sample_valid, frame_start, pixel_x,
        input  sample_ready, display_value, display_valid, capture_done
    );
endinterface

// File: rtl/scope_trace_scheduler.sv
// Double-buffered oscilloscope trace scheduler. One bank captures DEPTH
// samples after a trigger while the other bank is read column by column for
// display; the banks swap only at frame_start so a frame never tears.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    scope_trace_scheduler_if.slave (sample stream, pixel_x,
//          display_value/valid, frame_start, capture_done, enable)
// Configuration macro: SCOPE_TRIGGER_EN
//   defined   ARMED waits for a rising crossing of TRIG_LEVEL
//   undefined free-run, first accepted sample in ARMED starts the capture
module scope_trace_scheduler #(
    parameter int          DEPTH      = 640,
    parameter logic [11:0] TRIG_LEVEL = 12'd2048
) (
    input logic                     clk,
    input logic                     rst_n,
    scope_trace_scheduler_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

    state_t          state, state_d;
    logic [AW-1:0]   wr_idx, wr_idx_d, wr_addr;
    logic [11:0]     prev_sample, prev_d;
    logic            bank_sel;      // bank currently displayed; the other captures
    logic            wr_en, swap, xfer, trig;
    logic [11:0]     mem0 [DEPTH];
    logic [11:0]     mem1 [DEPTH];
    logic            in_range;
    logic [AW-1:0]   rd_addr;
    logic [11:0]     rd_data;

    assign bus.sample_ready = (state == ARMED) || (state == CAPTURE);
    assign xfer = bus.sample_valid && bus.sample_ready;

`ifdef SCOPE_TRIGGER_EN
    assign trig = (prev_sample < TRIG_LEVEL) && (bus.sample_in >= TRIG_LEVEL);
`else
    // Free-run: any accepted sample in ARMED starts the trace.
    logic unused_cfg;
    assign unused_cfg = ^{TRIG_LEVEL, prev_sample};
    assign trig = 1'b1;
`endif

    always_comb begin
        state_d  = state;
        wr_idx_d = wr_idx;
        prev_d   = prev_sample;
        wr_en    = 1'b0;
        wr_addr  = wr_idx;
        swap     = 1'b0;
        case (state)
            IDLE: begin
                wr_idx_d = '0;
                if (bus.enable) begin
                    state_d = ARMED;
                    prev_d  = 12'hFFF;   // first accepted sample cannot trigger
                end
            end
            ARMED: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    prev_d = bus.sample_in;
                    if (trig) begin
                        wr_en    = 1'b1;
                        wr_addr  = '0;
                        wr_idx_d = AW'(1);
                        state_d  = (DEPTH == 1) ? HOLD : CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (!bus.enable) begin
                    state_d = IDLE;      // partial trace is simply abandoned
                end else if (xfer) begin
                    wr_en = 1'b1;
                    if (wr_idx == AW'(DEPTH - 1)) state_d = HOLD;
                    else                          wr_idx_d = wr_idx + AW'(1);
                end
            end
            HOLD: begin
                if (bus.frame_start) begin
                    swap = 1'b1;
                    if (bus.enable) begin
                        state_d = ARMED;
                        prev_d  = 12'hFFF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            wr_idx            <= '0;
            prev_sample       <= 12'hFFF;
            bank_sel          <= 1'b0;
            bus.capture_done  <= 1'b0;
            bus.display_valid <= 1'b0;
        end else begin
            state             <= state_d;
            wr_idx            <= wr_idx_d;
            prev_sample       <= prev_d;
            bank_sel          <= bank_sel ^ swap;
            bus.capture_done  <= swap;
            bus.display_valid <= bus.display_valid | swap;
        end
    end

    // Sample memory is not reset; display_valid hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (bank_sel) mem0[wr_addr] <= bus.sample_in;
            else          mem1[wr_addr] <= bus.sample_in;
        end
    end

    assign in_range = int'(bus.pixel_x) < DEPTH;
    assign rd_addr  = in_range ? AW'(bus.pixel_x) : '0;
    assign rd_data  = bank_sel ? mem1[rd_addr] : mem0[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              bus.display_value <= '0;
        else if (bus.display_valid && in_range)  bus.display_value <= rd_data;
        else                                     bus.display_value <= '0;
    end
endmodule

// File: tb/tb_scope_trace_scheduler.sv
// Directed bench for scope_trace_scheduler (DEPTH=640). Expectations adapt to
// whether SCOPE_TRIGGER_EN is defined for the build.
module tb_scope_trace_scheduler;
    localparam int DEPTH = 640;
`ifdef SCOPE_TRIGGER_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0, n_pass = 0, n_fail = 0;

    scope_trace_scheduler_if bus ();

    scope_trace_scheduler #(.DEPTH(DEPTH), .TRIG_LEVEL(12'd2048)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        bus.sample_in    = v;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic show(input logic [9:0] x);
        bus.pixel_x = x;
        tick();
    endtask

    initial begin
        bus.enable       = 1'b0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.frame_start  = 1'b0;
        bus.pixel_x      = '0;
        #3;
        chk("rst_ready",   bus.sample_ready,  0);
        chk("rst_dvalid",  bus.display_valid, 0);
        chk("rst_dvalue",  bus.display_value, 0);
        chk("rst_cdone",   bus.capture_done,  0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ready", bus.sample_ready, 0);

        // First trace: 100, 200, 3000 then a ramp
        bus.enable = 1'b1;
        tick();
        chk("armed_ready", bus.sample_ready, 1);
        send(12'd100);
        send(12'd200);
        send(12'd3000);
        for (int i = (TRIG ? 1 : 3); i < DEPTH; i++) send(12'(10 + i));
        chk("hold_ready",  bus.sample_ready,  0);
        chk("hold_dvalid", bus.display_valid, 0);
        tick();
        chk("hold_dvalue", bus.display_value, 0);

        pulse_frame();
        chk("swap1_cdone",  bus.capture_done,  1);
        chk("swap1_dvalid", bus.display_valid, 1);
        show(10'd0);
        chk("cdone_pulse",  bus.capture_done,  0);
        chk("t1_addr0",     bus.display_value, TRIG ? 3000 : 100);
        show(10'd5);
        chk("t1_addr5",     bus.display_value, 15);
        show(10'd700);
        chk("t1_x700",      bus.display_value, 0);
        show(10'd639);
        chk("t1_addr639",   bus.display_value, 649);
        chk("rearm_ready",  bus.sample_ready,  1);

        // Second trace, with a frame_start arriving mid-capture
        if (TRIG) send(12'd0);
        send(12'd2500);
        for (int i = 1; i < 300; i++) send(12'(1000 + i));
        pulse_frame();
        chk("midcap_cdone",  bus.capture_done,  0);
        chk("midcap_dvalue", bus.display_value, 649);
        for (int i = 300; i < DEPTH; i++) send(12'(1000 + i));
        chk("t2_hold_ready", bus.sample_ready, 0);
        pulse_frame();
        chk("swap2_cdone", bus.capture_done, 1);
        show(10'd0);
        chk("t2_addr0",    bus.display_value, 2500);
        show(10'd300);
        chk("t2_addr300",  bus.display_value, 1300);

        // Abort at wr_idx=100, then re-enable with 4000 first
        if (TRIG) send(12'd0);
        send(12'd3000);
        for (int i = 1; i < 100; i++) send(12'd7);
        bus.enable = 1'b0;
        tick();
        chk("abort_ready", bus.sample_ready, 0);
        show(10'd0);
        chk("abort_dvalue", bus.display_value, 2500);
        chk("abort_dvalid", bus.display_valid, 1);
        bus.enable = 1'b1;
        tick();
        chk("reen_ready", bus.sample_ready, 1);
        for (int i = 0; i < DEPTH; i++) send(12'd4000);
        chk("no_trig_ready", bus.sample_ready, TRIG ? 1 : 0);
        pulse_frame();
        chk("t3_cdone", bus.capture_done, TRIG ? 0 : 1);
        show(10'd0);
        chk("t3_addr0", bus.display_value, TRIG ? 2500 : 4000);

        // Reset in the middle of a capture
        send(12'd100);
        send(12'd3000);
        for (int i = 0; i < 5; i++) send(12'(i));
        chk("precut_ready", bus.sample_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("cut_ready",  bus.sample_ready,  0);
        chk("cut_dvalid", bus.display_valid, 0);
        chk("cut_dvalue", bus.display_value, 0);
        chk("cut_cdone",  bus.capture_done,  0);
        bus.enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_dvalue", bus.display_value, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
